csr_unit: RTL

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 50 +++++
 rtl/csr_timer.sv | 49 ++++
 rtl/csr_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// CSR address map, field positions, reset values and exception codes
// shared by the CSR unit and its timer.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_W            = 5;
    localparam int PRMD_W            = 3;
    localparam int LIE_W             = 13;
    localparam int CRMD_IE_BIT       = 2;
    localparam int TCFG_EN_BIT       = 0;
    localparam int TCFG_PERIODIC_BIT = 1;
    localparam int TICLR_CLR_BIT     = 0;

    localparam logic [CRMD_W-1:0] CRMD_RESET = 5'b01000;
    // LIE bit 10 is reserved and never takes a written value.
    localparam logic [LIE_W-1:0]  LIE_WMASK  = 13'h1BFF;

    typedef enum logic [5:0] {
        ECODE_INT = 6'h00,
        ECODE_PIL = 6'h01,
        ECODE_PIS = 6'h02,
        ECODE_PIF = 6'h03,
        ECODE_PME = 6'h04,
        ECODE_PPI = 6'h07,
        ECODE_ADE = 6'h08,
        ECODE_ALE = 6'h09,
        ECODE_SYS = 6'h0B,
        ECODE_BRK = 6'h0C,
        ECODE_INE = 6'h0D,
        ECODE_IPE = 6'h0E,
        ECODE_FPD = 6'h0F
    } ecode_e;

    function automatic logic [31:0] timer_reload(input logic [31:0] tcfg_word);
        return {tcfg_word[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/csr_timer.sv
// TCFG/TVAL down-counter: loads on TCFG write, counts while enabled,
// pulses fire on the 1->0 step and optionally reloads.
module csr_timer
    import csr_pkg::*;
#(
    parameter int TIMER_W = 32
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tcfg_we,
    input  logic [31:0]        tcfg_wdata,
    output logic [31:0]        tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               fire
);

    logic [31:0]        wr_reload_full;
    logic [31:0]        cur_reload_full;
    logic [TIMER_W-1:0] wr_reload;
    logic [TIMER_W-1:0] cur_reload;
    logic               counting;
    logic               last_tick;

    assign wr_reload_full  = timer_reload(tcfg_wdata);
    assign cur_reload_full = timer_reload(tcfg);
    assign wr_reload       = wr_reload_full[TIMER_W-1:0];
    assign cur_reload      = cur_reload_full[TIMER_W-1:0];

    assign counting  = tcfg[TCFG_EN_BIT] && (tval != '0);
    assign last_tick = counting && (tval == TIMER_W'(1));
    // A TCFG write restarts the count, so it also cancels a pending expiry.
    assign fire      = last_tick && !tcfg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcfg <= '0;
            tval <= '0;
        end else if (tcfg_we) begin
            tcfg <= tcfg_wdata;
            tval <= wr_reload;
        end else if (last_tick) begin
            tval <= tcfg[TCFG_PERIODIC_BIT] ? cur_reload : '0;
        end else if (counting) begin
            tval <= tval - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Privileged CSR file: exception entry/return bookkeeping, interrupt status
// and enables, scratch registers and the interval timer.
module csr_unit
    import csr_pkg::*;
#(
    parameter int SAVE_NUM = 4,
    parameter int TIMER_W  = 32
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic [13:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [13:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        ex_valid,
    input  logic [5:0]  ex_ecode,
    input  logic [31:0] ex_pc,
    input  logic        ex_badv_we,
    input  logic [31:0] ex_badv,
    input  logic        ertn_valid,
    input  logic [7:0]  hw_int,
    output logic        int_pending,
    output logic [31:0] ex_entry,
    output logic [31:0] era_out,
    output logic [1:0]  plv
);

    logic [CRMD_W-1:0]  crmd;
    logic [PRMD_W-1:0]  prmd;
    logic [LIE_W-1:0]   lie;
    logic [1:0]         is_sw;
    logic [7:0]         is_hw;
    logic               is_timer;
    logic [5:0]         ecode;
    logic [31:0]        era;
    logic [31:0]        badv;
    logic [25:0]        eentry;
    logic [31:0]        tid;
    logic [31:0]        save [SAVE_NUM];
    logic [31:0]        tcfg;
    logic [TIMER_W-1:0] tval;
    logic               timer_fire;

    logic               do_ertn;
    logic               we_crmd;
    logic               we_prmd;
    logic               we_ecfg;
    logic               we_estat;
    logic               we_era;
    logic               we_badv;
    logic               we_eentry;
    logic               we_tid;
    logic               we_tcfg;
    logic               clr_timer;
    logic [12:0]        is_all;

    // An exception outranks a simultaneous return, and a write to any CSR
    // that the committing event itself updates is discarded.
    assign do_ertn   = ertn_valid && !ex_valid;
    assign we_crmd   = csr_we && (csr_addr == CSR_CRMD) && !ex_valid && !do_ertn;
    assign we_prmd   = csr_we && (csr_addr == CSR_PRMD) && !ex_valid;
    assign we_ecfg   = csr_we && (csr_addr == CSR_ECFG);
    assign we_estat  = csr_we && (csr_addr == CSR_ESTAT) && !ex_valid;
    assign we_era    = csr_we && (csr_addr == CSR_ERA) && !ex_valid;
    assign we_badv   = csr_we && (csr_addr == CSR_BADV) && !(ex_valid && ex_badv_we);
    assign we_eentry = csr_we && (csr_addr == CSR_EENTRY);
    assign we_tid    = csr_we && (csr_addr == CSR_TID);
    assign we_tcfg   = csr_we && (csr_addr == CSR_TCFG);
    assign clr_timer = csr_we && (csr_addr == CSR_TICLR) && csr_wdata[TICLR_CLR_BIT];

    csr_timer #(
        .TIMER_W    (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .tcfg_we    (we_tcfg),
        .tcfg_wdata (csr_wdata),
        .tcfg       (tcfg),
        .tval       (tval),
        .fire       (timer_fire)
    );

    // CRMD[2:0] = {IE, PLV} lines up with PRMD[2:0] = {PIE, PPLV}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crmd <= CRMD_RESET;
        end else if (ex_valid) begin
            crmd <= {crmd[CRMD_W-1:3], 3'b000};
        end else if (do_ertn) begin
            crmd <= {crmd[CRMD_W-1:3], prmd};
        end else if (we_crmd) begin
            crmd <= csr_wdata[CRMD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prmd <= '0;
        end else if (ex_valid) begin
            prmd <= crmd[PRMD_W-1:0];
        end else if (we_prmd) begin
            prmd <= csr_wdata[PRMD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lie    <= '0;
            eentry <= '0;
            tid    <= '0;
        end else begin
            if (we_ecfg) begin
                lie <= csr_wdata[LIE_W-1:0] & LIE_WMASK;
            end
            if (we_eentry) begin
                eentry <= csr_wdata[31:6];
            end
            if (we_tid) begin
                tid <= csr_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_sw <= '0;
            is_hw <= '0;
            ecode <= '0;
        end else begin
            is_hw <= hw_int;
            if (we_estat) begin
                is_sw <= csr_wdata[1:0];
            end
            if (ex_valid) begin
                ecode <= ex_ecode;
            end
        end
    end

    // An expiry on the same edge as a TICLR write leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_timer <= 1'b0;
        end else if (timer_fire) begin
            is_timer <= 1'b1;
        end else if (clr_timer) begin
            is_timer <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            era  <= '0;
            badv <= '0;
        end else begin
            if (ex_valid) begin
                era <= ex_pc;
            end else if (we_era) begin
                era <= csr_wdata;
            end
            if (ex_valid && ex_badv_we) begin
                badv <= ex_badv;
            end else if (we_badv) begin
                badv <= csr_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SAVE_NUM; i++) begin
                save[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SAVE_NUM; i++) begin
                if (csr_we && (csr_addr == CSR_SAVE0 + 14'(i))) begin
                    save[i] <= csr_wdata;
                end
            end
        end
    end

    assign is_all = {1'b0, is_timer, 1'b0, is_hw, is_sw};

    // Reads see register state only; a same-cycle write is not forwarded.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CSR_CRMD:   rd_data = 32'(crmd);
            CSR_PRMD:   rd_data = 32'(prmd);
            CSR_ECFG:   rd_data = 32'(lie);
            CSR_ESTAT:  rd_data = {10'b0, ecode, 3'b0, is_all};
            CSR_ERA:    rd_data = era;
            CSR_BADV:   rd_data = badv;
            CSR_EENTRY: rd_data = {eentry, 6'b0};
            CSR_TID:    rd_data = tid;
            CSR_TCFG:   rd_data = tcfg;
            CSR_TVAL:   rd_data = 32'(tval);
            default:    rd_data = '0;
        endcase
        for (int i = 0; i < SAVE_NUM; i++) begin
            if (rd_addr == CSR_SAVE0 + 14'(i)) begin
                rd_data = save[i];
            end
        end
    end

    assign int_pending = crmd[CRMD_IE_BIT] & (|(is_all & lie));
    assign ex_entry    = {eentry, 6'b0};
    assign era_out     = era;
    assign plv         = crmd[1:0];

endmodule
